// File: rtl/boot_word_packer_if.sv
// Byte-stream and word-output bundle between the boot byte reader, the packer and the word register.
interface boot_word_packer_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 24
) ();
  logic                  cl;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  flush;
  logic [WIDTH-1:0]      word_out;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  word_w;
  logic                  word_ack;
  logic [15:0]           word_count;

  modport master (
    output cl, start_addr, byte_in, byte_valid, flush, word_ack,
    input  byte_ready, word_out, word_addr, word_w, word_count
  );

  modport slave (
    input  cl, start_addr, byte_in, byte_valid, flush, word_ack,
    output byte_ready, word_out, word_addr, word_w, word_count
  );
endinterface

// File: rtl/boot_word_packer.sv
// Packs boot bytes MSB-first into WIDTH-bit words, strobes each word once and stalls until acknowledged.
module boot_word_packer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 24
) (
  input logic              clk,
  input logic              rst_n,
  boot_word_packer_if.slave bus
);
  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned IW = $clog2(NB);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] buffer;
  logic [WIDTH-1:0] merged;
  logic             accept;
  logic             last;
  logic             emit;

  // The buffer is zeroed after every word, so unfilled byte lanes are already the zero padding.
  always_comb begin
    accept = bus.byte_valid && bus.byte_ready;
    merged = buffer;
    for (int k = 0; k < int'(NB); k++) begin
      if (accept && (idx == IW'(k))) begin
        merged[WIDTH-1-8*k -: 8] = bus.byte_in;
      end
    end
    last = accept && (idx == IW'(NB - 1));
    emit = (state == FILL) && (last || (bus.flush && ((idx != '0) || accept)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= FILL;
      bus.byte_ready <= 1'b1;
      idx            <= '0;
      buffer         <= '0;
      bus.word_out   <= '0;
      bus.word_addr  <= '0;
      bus.word_w     <= 1'b0;
      bus.word_count <= '0;
    end else begin
      bus.word_w <= 1'b0;
      if (bus.cl) begin
        state          <= FILL;
        bus.byte_ready <= 1'b1;
        idx            <= '0;
        buffer         <= '0;
        bus.word_addr  <= bus.start_addr;
        bus.word_count <= '0;
      end else begin
        case (state)
          FILL: begin
            if (emit) begin
              bus.word_out   <= merged;
              bus.word_w     <= 1'b1;
              buffer         <= '0;
              idx            <= '0;
              state          <= HOLD;
              bus.byte_ready <= 1'b0;
            end else if (accept) begin
              buffer <= merged;
              idx    <= idx + IW'(1);
            end
          end
          HOLD: begin
            if (bus.word_ack) begin
              bus.word_addr  <= bus.word_addr + ADDR_WIDTH'(NB);
              bus.word_count <= bus.word_count + 16'd1;
              state          <= FILL;
              bus.byte_ready <= 1'b1;
            end
          end
          default: begin
            state          <= FILL;
            bus.byte_ready <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_boot_word_packer.sv
// Scoreboard bench for boot_word_packer: directed byte streams, expected words queued, monitor checks strobes.
module tb_boot_word_packer;
  logic clk;
  logic rst_n;

  boot_word_packer_if #(.WIDTH(32), .ADDR_WIDTH(24)) bus ();

  boot_word_packer #(.WIDTH(32), .ADDR_WIDTH(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] word;
    logic [23:0] addr;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.word_w) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word_w: got strobe with word_out 0x%0h, expected none (t=%0t)",
                 bus.word_out, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("word_out", 64'(bus.word_out), 64'(e.word));
        check("word_addr", 64'(bus.word_addr), 64'(e.addr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
  endtask

  task automatic ack();
    bus.word_ack = 1'b1;
    tick();
    bus.word_ack = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [23:0] a);
    exp_t e;
    e.word = w;
    e.addr = a;
    q.push_back(e);
  endtask

  task automatic clear(input logic [23:0] a);
    bus.start_addr = a;
    bus.cl         = 1'b1;
    tick();
    bus.cl         = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.cl         = 1'b0;
    bus.start_addr = '0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.word_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_byte_ready", 64'(bus.byte_ready), 64'd1);
    check("rst_word_out", 64'(bus.word_out), 64'd0);
    check("rst_word_addr", 64'(bus.word_addr), 64'd0);
    check("rst_word_w", 64'(bus.word_w), 64'd0);
    check("rst_word_count", 64'(bus.word_count), 64'd0);

    // Basic word, ack in the strobe cycle
    clear(24'h000100);
    expect_word(32'h11223344, 24'h000100);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("hold_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("strobe_now", 64'(bus.word_w), 64'd1);
    ack();
    check("after_ack_ready", 64'(bus.byte_ready), 64'd1);
    check("after_ack_w", 64'(bus.word_w), 64'd0);
    check("count1", 64'(bus.word_count), 64'd1);
    check("addr1", 64'(bus.word_addr), 64'h000104);

    expect_word(32'hA0A1A2A3, 24'h000104);
    send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
    ack();
    expect_word(32'hA4A5A6A7, 24'h000108);
    send(8'hA4); send(8'hA5); send(8'hA6); send(8'hA7);
    ack();
    check("count3", 64'(bus.word_count), 64'd3);

    // Delayed ack with the byte source pushing
    expect_word(32'hB0B1B2B3, 24'h00010C);
    send(8'hB0); send(8'hB1); send(8'hB2); send(8'hB3);
    bus.byte_in    = 8'hEE;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_ready", 64'(bus.byte_ready), 64'd0);
      check("stall_word", 64'(bus.word_out), 64'hB0B1B2B3);
    end
    ack();
    bus.byte_valid = 1'b0;
    check("count4", 64'(bus.word_count), 64'd4);

    // Partial word flush
    expect_word(32'hDEAD0000, 24'h000110);
    send(8'hDE); send(8'hAD);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_strobe", 64'(bus.word_w), 64'd1);
    ack();

    // Flush at idx 0 without a byte is a no-op
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    check("idle_flush_w", 64'(bus.word_w), 64'd0);
    check("idle_flush_ready", 64'(bus.byte_ready), 64'd1);

    // Flush together with the first byte of a word
    expect_word(32'h5A000000, 24'h000114);
    bus.byte_in    = 8'h5A;
    bus.byte_valid = 1'b1;
    bus.flush      = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    bus.flush      = 1'b0;
    ack();
    check("count6", 64'(bus.word_count), 64'd6);
    check("addr6", 64'(bus.word_addr), 64'h000118);

    // Address wrap
    clear(24'hFFFFFC);
    check("cl_count", 64'(bus.word_count), 64'd0);
    expect_word(32'hC0C1C2C3, 24'hFFFFFC);
    send(8'hC0); send(8'hC1); send(8'hC2); send(8'hC3);
    ack();
    expect_word(32'hC4C5C6C7, 24'h000000);
    send(8'hC4); send(8'hC5); send(8'hC6); send(8'hC7);
    ack();
    check("wrap_addr", 64'(bus.word_addr), 64'h000004);
    check("wrap_count", 64'(bus.word_count), 64'd2);

    // cl during HOLD discards the pending word
    expect_word(32'hD0D1D2D3, 24'h000004);
    send(8'hD0); send(8'hD1); send(8'hD2); send(8'hD3);
    tick();
    clear(24'h000200);
    check("clhold_ready", 64'(bus.byte_ready), 64'd1);
    check("clhold_count", 64'(bus.word_count), 64'd0);
    check("clhold_addr", 64'(bus.word_addr), 64'h000200);
    check("clhold_word", 64'(bus.word_out), 64'hD0D1D2D3);
    repeat (3) tick();

    // Async reset mid-word
    send(8'h91); send(8'h92);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_word_out", 64'(bus.word_out), 64'd0);
    check("arst_addr", 64'(bus.word_addr), 64'd0);
    check("arst_ready", 64'(bus.byte_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_word(32'h01020304, 24'h000000);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    ack();
    check("post_rst_count", 64'(bus.word_count), 64'd1);
    check("post_rst_addr", 64'(bus.word_addr), 64'h000004);

    repeat (3) tick();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/boot_word_packer.md
# boot_word_packer

Assembles the bootloader's incoming byte stream from the SD/SPI byte reader into WIDTH-bit words and presents each completed word, with its target address, to the downstream word register and wishbone write stage. Issues a single-cycle write strobe per word, then holds the word and stalls the byte source until the downstream stage acknowledges. Sits directly upstream of the bootloader's data register: word_out drives the register's din and word_w drives its w.

## Interface
Parameters:
- WIDTH, 32, word width in bits; must be a multiple of 8, at least 16.
- ADDR_WIDTH, 24, byte-address width of word_addr.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cl  input  1  synchronous clear: abandon partial/pending word, reload address.
- start_addr  input  ADDR_WIDTH  byte address of first word, sampled on cl.
- byte_in  input  8  incoming byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  packer can accept a byte this cycle.
- flush  input  1  zero-pad and emit a partial word.
- word_out  output  WIDTH  assembled word, first byte in MSBs.
- word_addr  output  ADDR_WIDTH  byte address of word_out.
- word_w  output  1  one-cycle write strobe for word_out.
- word_ack  input  1  downstream has consumed word_out.
- word_count  output  16  words acknowledged since reset/cl.

## Operation
- NB = WIDTH/8. Byte accepted when byte_valid && byte_ready. Byte index counter idx (0..NB-1). Byte k of a word goes to bits [WIDTH-1-8k -: 8].
- States: FILL (byte_ready=1), HOLD (byte_ready=0).
- FILL: on accept with idx<NB-1, store byte and idx++. On accept with idx=NB-1, store byte, idx<=0, load word_out from shift buffer, word_w<=1, go HOLD.
- flush in FILL with idx>0 (or idx=0 and a byte accepted the same cycle): include any byte accepted that cycle, zero-fill the remaining bytes, emit as a full word (word_w, HOLD), idx<=0. flush with idx=0 and no byte accepted: no effect. flush in HOLD: ignored.
- HOLD: word_out and word_addr stable. On word_ack: word_addr <= word_addr+NB (mod 2^ADDR_WIDTH), word_count++ (wraps at 16 bits), go FILL.
- word_ack in FILL: ignored.
- cl (priority over all other inputs, any state): idx<=0, buffer cleared, word_addr<=start_addr, word_count<=0, word_w<=0, state FILL; pending word is discarded and never re-strobed; word_out keeps its value.
- Reset values: state FILL, byte_ready 1, idx 0, word_out 0, word_addr 0, word_w 0, word_count 0.

## Timing
- Last byte accepted at edge N: word_out valid and word_w=1 in the cycle after N; word_w is 0 after edge N+1 regardless of ack.
- byte_ready drops in the cycle after edge N (registered state); no byte is accepted in that cycle.
- word_ack is honoured from the word_w cycle onward; ack sampled at edge N+1 gives byte_ready=1 in the cycle after N+1 (minimum 2-cycle word turnaround, NB+1 cycles per word at full rate).
- word_addr increments and word_count increments at the ack edge; word_addr in the word_w cycle is the address of that word.
- rst_n assertion clears everything immediately, mid-word or mid-HOLD; first edge after deassertion behaves as FILL with idx 0.

## Test plan
- Reset, cl with start_addr=0x000100, stream bytes 0x11,0x22,0x33,0x44 back-to-back -> word_out=0x11223344, word_addr=0x000100, one word_w pulse one cycle after 4th byte; byte_ready low until ack.
- Ack in the word_w cycle, then 8 more bytes 0xA0..0xA7 -> words 0xA0A1A2A3 @0x104, 0xA4A5A6A7 @0x108, word_count=3 after acks.
- Delay word_ack 10 cycles with byte_valid held high -> no byte accepted during HOLD, word_out stable, no second word_w.
- Send 0xDE,0xAD then flush -> word_out=0xDEAD0000; flush with idx=0 -> no word_w.
- start_addr=0xFFFFFC, two acknowledged words -> word_addr 0xFFFFFC then 0x000000.
- Assert cl during HOLD and rst_n low mid-word -> no word_w, byte_ready=1 next cycle, word_count=0, word_addr=start_addr (or 0 after reset).
